// File: rtl/postfix_eval_sequencer.sv
// Sequences STACK_BASED_ALU commands for a stream of postfix tokens and returns the final value.
// Operand 2 cycles, binary operator 7, terminator 3; tok_ready only in FETCH, errors/overflow drain the ALU stack.
module postfix_eval_sequencer #(
    parameter int n     = 8,
    parameter int DEPTH = 128
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [n-1:0] tok_data,
    input  logic         tok_is_op,
    output logic [2:0]   alu_opcode,
    output logic [n-1:0] alu_in,
    input  logic [n-1:0] alu_out,
    input  logic         alu_overflow,
    output logic [n-1:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         error
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    localparam logic [n-1:0] TOK_ADD = n'(43);
    localparam logic [n-1:0] TOK_SUB = n'(45);
    localparam logic [n-1:0] TOK_MUL = n'(42);
    localparam logic [n-1:0] TOK_END = n'(36);

    typedef enum logic [3:0] {
        IDLE, FETCH, PUSH_N, POP_B, PUSH_B, EXEC, POP1, POP2, PUSH_R, FIN_POP, CAPT, DRAIN
    } state_t;

    state_t          state_q;
    logic [2:0]      opcode_q;
    logic [n-1:0]    alu_in_q;
    logic [n-1:0]    r_q;
    logic [n-1:0]    result_q;
    logic            result_valid_q;
    logic            busy_q;
    logic            error_q;
    logic            tok_ready_q;
    logic            op_mul_q;
    logic            op_sub_q;
    logic [DW-1:0]   depth_q;

    logic fetch_hs;
    logic is_arith;
    logic tok_bad;
    logic abort;

    // depth_q already includes the command currently on alu_opcode, so the checks see post-command occupancy
    always_comb begin
        fetch_hs = (state_q == FETCH) && tok_valid && tok_ready_q;
        is_arith = (tok_data == TOK_ADD) || (tok_data == TOK_SUB) || (tok_data == TOK_MUL);
        tok_bad  = 1'b0;
        if (!tok_is_op) begin
            tok_bad = (depth_q == DEPTH_C);
        end else if (is_arith) begin
            tok_bad = (depth_q < DW'(2));
        end else if (tok_data == TOK_END) begin
            tok_bad = (depth_q != DW'(1));
        end else begin
            tok_bad = 1'b1;
        end
        abort = (alu_overflow && (state_q != IDLE) && (state_q != DRAIN)) || (fetch_hs && tok_bad);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= IDLE;
            opcode_q       <= OP_NOP;
            alu_in_q       <= '0;
            r_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            tok_ready_q    <= 1'b0;
            op_mul_q       <= 1'b0;
            op_sub_q       <= 1'b0;
            depth_q        <= '0;
        end else begin
            opcode_q       <= OP_NOP;
            result_valid_q <= 1'b0;
            tok_ready_q    <= 1'b0;
            if (abort) begin
                state_q <= DRAIN;
                error_q <= 1'b1;
                if (depth_q != '0) begin
                    opcode_q <= OP_POP;
                    depth_q  <= depth_q - DW'(1);
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q     <= FETCH;
                            busy_q      <= 1'b1;
                            error_q     <= 1'b0;
                            tok_ready_q <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (fetch_hs) begin
                            if (!tok_is_op) begin
                                state_q  <= PUSH_N;
                                opcode_q <= OP_PUSH;
                                alu_in_q <= tok_data;
                                depth_q  <= depth_q + DW'(1);
                            end else if (is_arith) begin
                                state_q  <= POP_B;
                                opcode_q <= OP_POP;
                                op_mul_q <= (tok_data == TOK_MUL);
                                op_sub_q <= (tok_data == TOK_SUB);
                                depth_q  <= depth_q - DW'(1);
                            end else begin
                                state_q  <= FIN_POP;
                                opcode_q <= OP_POP;
                                depth_q  <= depth_q - DW'(1);
                            end
                        end else begin
                            tok_ready_q <= 1'b1;
                        end
                    end
                    PUSH_N: begin
                        state_q     <= FETCH;
                        tok_ready_q <= 1'b1;
                    end
                    POP_B: begin
                        state_q  <= PUSH_B;
                        opcode_q <= OP_PUSH;
                        depth_q  <= depth_q + DW'(1);
                    end
                    PUSH_B: begin
                        state_q  <= EXEC;
                        opcode_q <= op_mul_q ? OP_MUL : OP_ADD;
                    end
                    EXEC: begin
                        state_q  <= POP1;
                        opcode_q <= OP_POP;
                        depth_q  <= depth_q - DW'(1);
                    end
                    POP1: begin
                        state_q  <= POP2;
                        opcode_q <= OP_POP;
                        r_q      <= alu_out;
                        depth_q  <= depth_q - DW'(1);
                    end
                    POP2: begin
                        state_q  <= PUSH_R;
                        opcode_q <= OP_PUSH;
                        alu_in_q <= r_q;
                        depth_q  <= depth_q + DW'(1);
                    end
                    PUSH_R: begin
                        state_q     <= FETCH;
                        tok_ready_q <= 1'b1;
                    end
                    FIN_POP: begin
                        state_q <= CAPT;
                    end
                    CAPT: begin
                        state_q        <= IDLE;
                        busy_q         <= 1'b0;
                        result_q       <= alu_out;
                        result_valid_q <= 1'b1;
                    end
                    DRAIN: begin
                        if (depth_q != '0) begin
                            opcode_q <= OP_POP;
                            depth_q  <= depth_q - DW'(1);
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The popped B operand only appears on alu_out during PUSH_B, so it is forwarded combinationally
    assign alu_in       = (state_q == PUSH_B) ? (op_sub_q ? -alu_out : alu_out) : alu_in_q;
    assign alu_opcode   = opcode_q;
    assign tok_ready    = tok_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule
